descrambler_ber_monitor: RTL and testbench

//  Downstream neighbour of the 64b/66b block synchronizer. Takes aligned 66-bit blocks (2-bit type + 64-bit payload)
//  and descrambles the payload with the self-synchronising x^58+x^39+1 polynomial. Flags illegal sync headers,

---
 rtl/descrambler_ber_monitor.sv | 130 +++++++++++++
 tb/tb_descrambler_ber_monitor.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/descrambler_ber_monitor.sv
`timescale 1ns/1ps
// 64b/66b payload descrambler (x^58+x^39+1) with illegal-header flagging, hi-BER window monitor
// and saturating header-error counter. One register stage, skid-free valid/ready.
module descrambler_ber_monitor #(
  parameter bit          BYPASS       = 1'b0,
  parameter int unsigned WINDOW_WORDS = 19531,
  parameter int unsigned BER_THRESH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  s_axis_ttype,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [1:0]  m_axis_ttype,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        err_clear,
  output logic [31:0] err_count,
  output logic        hi_ber
);

  localparam int WIN_W = (WINDOW_WORDS > 1) ? $clog2(WINDOW_WORDS) : 1;
  localparam int BAD_W = $clog2(BER_THRESH + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_WORDS - 1);
  localparam logic [BAD_W-1:0] BAD_MAX  = BAD_W'(BER_THRESH);

  logic [57:0]      st_q, st_d;
  logic             vld_q, vld_d;
  logic [1:0]       type_q, type_d;
  logic [63:0]      dat_q, dat_d;
  logic             user_q, user_d;
  logic [31:0]      err_count_q, err_count_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [BAD_W-1:0] bad_q, bad_d;
  logic             hi_q, hi_d;

  logic             accept;
  logic             hdr_bad;
  logic [63:0]      descr;
  logic [63:0]      payload;
  logic [BAD_W-1:0] bad_now;

  assign s_axis_tready = !vld_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign hdr_bad       = accept && (s_axis_ttype == 2'b00 || s_axis_ttype == 2'b11);

  // Bit i sees the line bits 39 and 58 positions earlier; the oldest ones come from st_q.
  assign descr   = s_axis_tdata
                 ^ {s_axis_tdata[24:0], st_q[57:19]}
                 ^ {s_axis_tdata[5:0],  st_q};
  assign payload = BYPASS ? s_axis_tdata : descr;

  always_comb begin
    st_d        = st_q;
    vld_d       = vld_q;
    type_d      = type_q;
    dat_d       = dat_q;
    user_d      = user_q;
    err_count_d = err_count_q;
    win_d       = win_q;
    bad_d       = bad_q;
    hi_d        = hi_q;
    bad_now     = bad_q;

    if (accept) begin
      st_d   = s_axis_tdata[63:6];
      vld_d  = 1'b1;
      type_d = s_axis_ttype;
      dat_d  = payload;
      user_d = hdr_bad;
    end else if (m_axis_tready) begin
      vld_d = 1'b0;
    end

    if (err_clear) begin
      err_count_d = '0;
    end else if (hdr_bad && err_count_q != 32'hFFFF_FFFF) begin
      err_count_d = err_count_q + 32'd1;
    end

    if (accept) begin
      bad_now = bad_q + BAD_W'(hdr_bad && bad_q != BAD_MAX);
      if (bad_now == BAD_MAX) hi_d = 1'b1;
      // The clear decision is taken only on the last word of a window.
      if (win_q == WIN_LAST) begin
        if (bad_now < BAD_MAX) hi_d = 1'b0;
        win_d = '0;
        bad_d = '0;
      end else begin
        win_d = win_q + WIN_W'(1);
        bad_d = bad_now;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q        <= '0;
      vld_q       <= 1'b0;
      type_q      <= '0;
      dat_q       <= '0;
      user_q      <= 1'b0;
      err_count_q <= '0;
      win_q       <= '0;
      bad_q       <= '0;
      hi_q        <= 1'b0;
    end else begin
      st_q        <= st_d;
      vld_q       <= vld_d;
      type_q      <= type_d;
      dat_q       <= dat_d;
      user_q      <= user_d;
      err_count_q <= err_count_d;
      win_q       <= win_d;
      bad_q       <= bad_d;
      hi_q        <= hi_d;
    end
  end

  assign m_axis_tvalid = vld_q;
  assign m_axis_ttype  = type_q;
  assign m_axis_tdata  = dat_q;
  assign m_axis_tuser  = user_q;
  assign err_count     = err_count_q;
  assign hi_ber        = hi_q;

endmodule

// File: tb/tb_descrambler_ber_monitor.sv
`timescale 1ns/1ps
// Randomised bench for descrambler_ber_monitor: bit-serial line model, word scoreboard,
// window-arithmetic BER model; a BYPASS=1 copy shares the stimulus.
module tb_descrambler_ber_monitor;

  localparam int W  = 100;
  localparam int TH = 16;
  localparam int NW = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  s_ttype;
  logic [63:0] s_tdata;
  logic        s_tvalid, m_tready, err_clear;
  logic        s_tready, m_tuser, m_tvalid, hi_ber;
  logic [1:0]  m_ttype;
  logic [63:0] m_tdata;
  logic [31:0] err_count;
  logic        b_s_tready, b_tuser, b_tvalid, b_hi;
  logic [1:0]  b_ttype;
  logic [63:0] b_tdata;
  logic [31:0] b_err;

  descrambler_ber_monitor #(.BYPASS(1'b0), .WINDOW_WORDS(W), .BER_THRESH(TH)) dut (
    .clk(clk), .reset(reset),
    .s_axis_ttype(s_ttype), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_ttype(m_ttype), .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .err_clear(err_clear), .err_count(err_count), .hi_ber(hi_ber));

  descrambler_ber_monitor #(.BYPASS(1'b1), .WINDOW_WORDS(W), .BER_THRESH(TH)) dut_byp (
    .clk(clk), .reset(reset),
    .s_axis_ttype(s_ttype), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(b_s_tready),
    .m_axis_ttype(b_ttype), .m_axis_tdata(b_tdata), .m_axis_tuser(b_tuser), .m_axis_tvalid(b_tvalid),
    .m_axis_tready(m_tready), .err_clear(err_clear), .err_count(b_err), .hi_ber(b_hi));

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // reference model state
  logic        e_vld, e_user, e_hi;
  logic [1:0]  e_type;
  logic [63:0] e_dat, e_raw;
  logic [31:0] e_err;
  int          n_acc, win_bad;
  bit          hist[$];

  logic [63:0] orig_w[NW];
  logic [63:0] scr_w[NW];
  logic [1:0]  type_w[NW];
  logic [63:0] sb_dat[$];
  int          sb_idx[$];
  logic        cur_sb;
  int          cur_idx;
  logic [63:0] cur_org;
  bit          rand_gap, rand_rdy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    e_vld = 0; e_user = 0; e_hi = 0; e_err = 0; e_type = 0; e_dat = 0; e_raw = 0;
    n_acc = 0; win_bad = 0;
    hist.delete();
    repeat (58) hist.push_back(1'b0);
    sb_dat.delete(); sb_idx.delete();
  endtask

  // Line-order descrambling: each output bit = rx bit ^ rx bit 39 earlier ^ rx bit 58 earlier.
  task automatic descr_model(input logic [63:0] d, output logic [63:0] o);
    for (int i = 0; i < 64; i++) begin
      o[i] = d[i] ^ hist[hist.size()-39] ^ hist[hist.size()-58];
      hist.push_back(d[i]);
      void'(hist.pop_front());
    end
  endtask

  function automatic logic is_bad(input logic [1:0] t);
    return (t == 2'b00) || (t == 2'b11);
  endfunction

  task automatic model_accept();
    logic [63:0] o;
    logic        bad;
    int          pos;
    descr_model(s_tdata, o);
    bad = is_bad(s_ttype);
    e_vld = 1; e_dat = o; e_raw = s_tdata; e_type = s_ttype; e_user = bad;
    pos = n_acc % W;
    if (pos == 0) win_bad = 0;
    if (bad) win_bad++;
    if (win_bad >= TH) e_hi = 1;
    if (pos == W - 1 && win_bad < TH) e_hi = 0;
    n_acc++;
    if (cur_sb) begin
      sb_idx.push_back(cur_idx);
      sb_dat.push_back(cur_org);
    end
  endtask

  // One clock: inputs already driven; predict the edge, then compare at the following negedge.
  task automatic step(output bit acc);
    logic [63:0] org;
    int          idx;
    #1;
    acc = s_tvalid && s_tready;
    chk("s_tready", s_tready, !e_vld || m_tready);
    if (e_vld && m_tready && sb_idx.size() > 0) begin
      idx = sb_idx.pop_front();
      org = sb_dat.pop_front();
      if (idx >= 1) chk("sb_data", m_tdata, org);
    end
    if (err_clear) e_err = 0;
    else if (acc && is_bad(s_ttype) && e_err != 32'hFFFF_FFFF) e_err = e_err + 1;
    if (acc) model_accept();
    else if (m_tready) e_vld = 0;
    @(negedge clk);
    chk("m_tvalid", m_tvalid, e_vld);
    chk("byp_tvalid", b_tvalid, e_vld);
    if (e_vld) begin
      chk("m_ttype", m_ttype, e_type);
      chk("m_tdata", m_tdata, e_dat);
      chk("m_tuser", m_tuser, e_user);
      chk("byp_tdata", b_tdata, e_raw);
    end
    chk("hi_ber", hi_ber, e_hi);
    chk("err_count", err_count, e_err);
  endtask

  task automatic send(input logic [1:0] t, input logic [63:0] d);
    bit acc;
    int tries;
    acc = 0; tries = 0;
    while (!acc && tries < 200) begin
      s_ttype  = t;
      s_tdata  = d;
      s_tvalid = !(rand_gap && $urandom_range(0, 3) == 0);
      m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      step(acc);
      tries++;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    s_tvalid = 0;
  endtask

  task automatic drain();
    bit acc;
    s_tvalid = 0;
    m_tready = 1;
    repeat (3) step(acc);
    chk("sb_empty", 64'(sb_idx.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1; s_tvalid = 0; m_tready = 1; err_clear = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_hi_ber", hi_ber, 0);
    chk("rst_err", err_count, 0);
    chk("rst_byp_tvalid", b_tvalid, 0);
    reset = 0;
  endtask

  task automatic gen_stream();
    bit sh[$];
    int r;
    repeat (58) sh.push_back(1'b1);
    for (int w = 0; w < NW; w++) begin
      orig_w[w] = {$urandom, $urandom};
      r = $urandom_range(0, 15);
      type_w[w] = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : r[0] ? 2'b10 : 2'b01;
      for (int i = 0; i < 64; i++) begin
        scr_w[w][i] = orig_w[w][i] ^ sh[sh.size()-39] ^ sh[sh.size()-58];
        sh.push_back(scr_w[w][i]);
        void'(sh.pop_front());
      end
    end
  endtask

  task automatic feed_stream();
    for (int w = 0; w < NW; w++) begin
      cur_sb = 1; cur_idx = w; cur_org = orig_w[w];
      send(type_w[w], scr_w[w]);
    end
    cur_sb = 0;
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    reset = 1; s_ttype = 0; s_tdata = 0; s_tvalid = 0; m_tready = 1; err_clear = 0;
    cur_sb = 0; cur_idx = 0; cur_org = 0; rand_gap = 0; rand_rdy = 0;
    gen_stream();

    // single known word from zero state
    do_reset();
    send(2'b01, 64'h1);
    chk("t1_data", m_tdata, 64'h0400_0080_0000_0001);
    chk("t1_user", m_tuser, 0);

    // full-rate random stream
    do_reset();
    feed_stream();

    // same stream with source gaps and sink backpressure
    do_reset();
    rand_gap = 1; rand_rdy = 1;
    feed_stream();
    rand_gap = 0; rand_rdy = 0;

    // hi-BER: 16 bad headers in window 0, clean window 1
    do_reset();
    for (int i = 0; i < 2 * W; i++) begin
      send((i >= 10 && i <= 25) ? 2'b00 : 2'b01, {$urandom, $urandom});
      if (i == 24)  chk("ber_below", hi_ber, 0);
      if (i == 25)  chk("ber_set", hi_ber, 1);
      if (i == 198) chk("ber_held", hi_ber, 1);
      if (i == 199) chk("ber_clear", hi_ber, 0);
    end
    chk("ber_err16", err_count, 16);

    // error counter saturation and clear priority
    force dut.err_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.err_count_q;
    e_err = 32'hFFFF_FFFE;
    chk("err_preload", err_count, 32'hFFFF_FFFE);
    repeat (3) send(2'b00, {$urandom, $urandom});
    chk("err_sat", err_count, 32'hFFFF_FFFF);
    err_clear = 1;
    send(2'b11, {$urandom, $urandom});
    err_clear = 0;
    chk("err_clear_wins", err_count, 0);

    // bypass copy and asynchronous reset with a held output
    send(2'b01, 64'hDEAD_BEEF_0123_4567);
    chk("byp_fixed", b_tdata, 64'hDEAD_BEEF_0123_4567);
    chk("byp_fixed_vld", b_tvalid, 1);
    repeat (16) send(2'b00, {$urandom, $urandom});
    chk("t6_hi", hi_ber, 1);
    s_tvalid = 0; m_tready = 0;
    step(acc);
    chk("t6_held", m_tvalid, 1);
    reset = 1;
    #1;
    chk("arst_tvalid", m_tvalid, 0);
    chk("arst_hi_ber", hi_ber, 0);
    chk("arst_byp_tvalid", b_tvalid, 0);
    model_reset();
    @(negedge clk);
    reset = 0;
    m_tready = 1;
    step(acc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
